// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: shares one multi-cycle multiplier between NUM_REQ requesters.
// Round-robin grant, one operation in flight at a time. The product comes back
// tagged with the requester index over a valid/ready channel. A watchdog aborts
// an operation whose multiplier never raises data_valid.
//
// Ports:
//   clk_i, rst_n_i, clk_en_i       clock, synchronous active-low reset, clock enable
//   req_valid_i / req_ready_o      per-requester request handshake (ready is one-hot)
//   req_operand_A_i/_B_i           packed operands, requester k at [k*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid_o / rsp_ready_i      response handshake
//   rsp_id_o, rsp_result_o         requester index and product of the response
//   rsp_error_o                    response is a watchdog abort (result forced to 0)
//   mul_operand_A_o/_B_o           operands to the multiplier
//   mul_valid_entry_o              start pulse to the multiplier
//   mul_result_i, mul_data_valid_i, mul_busy_i  multiplier result and status
module mul_share_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 16,
  localparam int unsigned ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            clk_en_i,
  input  logic [NUM_REQ-1:0]              req_valid_i,
  output logic [NUM_REQ-1:0]              req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_operand_A_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_operand_B_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [ID_WIDTH-1:0]             rsp_id_o,
  output logic [2*DATA_WIDTH-1:0]         rsp_result_o,
  output logic                            rsp_error_o,
  output logic [DATA_WIDTH-1:0]           mul_operand_A_o,
  output logic [DATA_WIDTH-1:0]           mul_operand_B_o,
  output logic                            mul_valid_entry_o,
  input  logic [2*DATA_WIDTH-1:0]         mul_result_i,
  input  logic                            mul_data_valid_i,
  input  logic                            mul_busy_i
);

  localparam int unsigned WdWidth = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                  state_q, state_d;
  logic [ID_WIDTH-1:0]     ptr_q, ptr_d;
  logic [ID_WIDTH-1:0]     id_q, id_d;
  logic [DATA_WIDTH-1:0]   op_a_q, op_a_d;
  logic [DATA_WIDTH-1:0]   op_b_q, op_b_d;
  logic [WdWidth-1:0]      wdog_q, wdog_d;
  logic [2*DATA_WIDTH-1:0] result_q, result_d;
  logic                    error_q, error_d;

  logic                    grant_found;
  logic [ID_WIDTH-1:0]     grant_id;
  logic [ID_WIDTH-1:0]     cand;

  // Search ptr+1, ptr+2, ... so the last served requester has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = ID_WIDTH'((32'(ptr_q) + i) % NUM_REQ);
      if (!grant_found && req_valid_i[cand]) begin
        grant_found = 1'b1;
        grant_id    = cand;
      end
    end
  end

  // Handshake strobes are suppressed while frozen so no transfer is signalled
  // on an edge the registers will not take.
  always_comb begin
    req_ready_o = '0;
    if (state_q == StIdle && grant_found && clk_en_i) begin
      req_ready_o[grant_id] = 1'b1;
    end
  end

  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    id_d              = id_q;
    op_a_d            = op_a_q;
    op_b_d            = op_b_q;
    wdog_d            = wdog_q;
    result_d          = result_q;
    error_d           = error_q;
    mul_valid_entry_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          id_d    = grant_id;
          op_a_d  = req_operand_A_i[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
          op_b_d  = req_operand_B_i[32'(grant_id) * DATA_WIDTH +: DATA_WIDTH];
          state_d = StIssue;
        end
      end
      StIssue: begin
        if (!mul_busy_i) begin
          mul_valid_entry_o = clk_en_i;
          wdog_d            = WdWidth'(TIMEOUT);
          state_d           = StWait;
        end
      end
      StWait: begin
        // A result arriving on the expiry cycle still wins.
        if (mul_data_valid_i) begin
          result_d = mul_result_i;
          error_d  = 1'b0;
          state_d  = StResp;
        end else if (wdog_q == WdWidth'(1)) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = StResp;
        end else begin
          wdog_d = wdog_q - WdWidth'(1);
        end
      end
      StResp: begin
        if (rsp_ready_i) begin
          ptr_d   = id_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      ptr_q    <= ID_WIDTH'(NUM_REQ - 1);
      id_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      wdog_q   <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else if (clk_en_i) begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      wdog_q   <= wdog_d;
      result_q <= result_d;
      error_q  <= error_d;
    end
  end

  assign rsp_valid_o     = (state_q == StResp);
  assign rsp_id_o        = id_q;
  assign rsp_result_o    = result_q;
  assign rsp_error_o     = error_q;
  assign mul_operand_A_o = op_a_q;
  assign mul_operand_B_o = op_b_q;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Bench for mul_share_arbiter with a 9-cycle signed multiplier stub.
module tb_mul_share_arbiter;

  localparam int MulLat = 9;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_en = 1'b1;
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] opa = '0;
  logic [127:0] opb = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_result;
  logic         rsp_error;
  logic [31:0]  mul_a, mul_b;
  logic         mul_ve;
  logic [63:0]  mul_res = '0;
  logic         mul_dv = 1'b0;
  logic         mul_busy = 1'b0;
  logic [3:0]   mul_cnt = '0;
  logic         never = 1'b0;

  typedef struct packed {
    logic [1:0]  id;
    logic [63:0] res;
    logic        err;
  } exp_t;
  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ve_count = 0;
  int ve_double = 0;

  mul_share_arbiter #(.NUM_REQ(4), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .clk_en_i          (clk_en),
    .req_valid_i       (req_valid),
    .req_ready_o       (req_ready),
    .req_operand_A_i   (opa),
    .req_operand_B_i   (opb),
    .rsp_valid_o       (rsp_valid),
    .rsp_ready_i       (rsp_ready),
    .rsp_id_o          (rsp_id),
    .rsp_result_o      (rsp_result),
    .rsp_error_o       (rsp_error),
    .mul_operand_A_o   (mul_a),
    .mul_operand_B_o   (mul_b),
    .mul_valid_entry_o (mul_ve),
    .mul_result_i      (mul_res),
    .mul_data_valid_i  (mul_dv),
    .mul_busy_i        (mul_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier stub: data_valid pulses MulLat cycles after valid_entry
  // (suppressed when never=1), busy in between.
  always @(posedge clk) begin
    if (!rst_n) begin
      mul_busy <= 1'b0;
      mul_dv   <= 1'b0;
      mul_cnt  <= '0;
      mul_res  <= '0;
    end else if (clk_en) begin
      mul_dv <= 1'b0;
      if (mul_busy) begin
        if (mul_cnt == 0) begin
          mul_busy <= 1'b0;
          mul_dv   <= !never;
        end else begin
          mul_cnt <= mul_cnt - 1'b1;
        end
      end else if (mul_ve) begin
        mul_busy <= 1'b1;
        mul_cnt  <= 4'(MulLat - 2);
        mul_res  <= {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b};
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Response monitor / scoreboard.
  initial forever begin
    @(negedge clk);
    if (rst_n && clk_en && rsp_valid && rsp_ready) begin
      if (q.size() == 0) begin
        check("unexpected_rsp", 64'(rsp_id), 64'hFFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 64'(rsp_id), 64'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("rsp_error", 64'(rsp_error), 64'(e.err));
      end
    end
  end

  // Count valid_entry pulses and any pulse longer than one enabled cycle.
  initial begin : ve_mon
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && clk_en) begin
        if (mul_ve) begin
          ve_count++;
          if (prev) ve_double++;
        end
        prev = mul_ve;
      end
    end
  end

  task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] b);
    opa[k*32 +: 32] = a;
    opb[k*32 +: 32] = b;
    req_valid[k] = 1'b1;
  endtask

  task automatic wait_ready(input int k);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[k] && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready[k]) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] res, input logic err, input logic push);
    exp_t e;
    set_req(k, a, b);
    if (push) begin
      e.id = 2'(k); e.res = res; e.err = err;
      q.push_back(e);
    end
    wait_ready(k);
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
  endtask

  task automatic wait_ve(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!mul_ve && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!mul_ve) check("valid_entry_timeout", 64'd0, 64'd1);
    c = cyc;
  endtask

  task automatic wait_rsp(output int c);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!rsp_valid) check("rsp_timeout", 64'd0, 64'd1);
    c = cyc;
  endtask

  initial begin
    int ve, rc, vb, n;
    logic [1:0]  h_id;
    logic [63:0] h_res;
    logic        h_err;
    exp_t e;

    // Reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    check("reset_valid_entry", 64'(mul_ve), 64'd0);
    check("reset_result", rsp_result, 64'd0);
    check("reset_req_ready", 64'(req_ready), 64'd0);

    // All requesters valid: grants 0,1,2,3,0,1,2,3
    for (int k = 0; k < 4; k++) begin
      opa[k*32 +: 32] = 32'(k + 1);
      opb[k*32 +: 32] = 32'd10;
    end
    for (int i = 0; i < 8; i++) begin
      e.id = 2'(i % 4); e.res = 64'((i % 4 + 1) * 10); e.err = 1'b0;
      q.push_back(e);
    end
    @(posedge clk); #1 req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == 4'h0 && n < 300) begin
        n++;
        @(negedge clk);
      end
      check("rr_grant", 64'(req_ready), 64'(4'b0001 << (i % 4)));
      @(posedge clk);
      if (i == 7) begin
        #1 req_valid = 4'h0;
      end
    end

    // Single request: 7 * -3
    wait_rsp(rc);
    @(posedge clk); #1;
    vb = ve_count;
    issue(2, 32'd7, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b1);
    wait_rsp(rc);
    @(posedge clk); #1;
    check("single_ve_pulses", 64'(ve_count - vb), 64'd1);

    // Response back-pressure for 20 cycles
    rsp_ready = 1'b0;
    issue(0, 32'd5, 32'd6, 64'd30, 1'b0, 1'b1);
    wait_rsp(rc);
    h_id = rsp_id; h_res = rsp_result; h_err = rsp_error;
    check("hold_first_result", h_res, 64'd30);
    @(posedge clk); #1;
    set_req(1, 32'hFFFF_FFFE, 32'hFFFF_FFFC);
    e.id = 2'd1; e.res = 64'd8; e.err = 1'b0;
    q.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("hold_stable",
            {58'd0, rsp_valid, rsp_id, rsp_error, mul_ve, |req_ready},
            {58'd0, 1'b1, h_id, h_err, 1'b0, 1'b0});
      check("hold_result", rsp_result, h_res);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("release_idle_grant", 64'(req_ready), 64'b0010);
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_rsp(rc);
    @(posedge clk); #1;

    // Watchdog: multiplier never returns data
    never = 1'b1;
    issue(3, 32'd9, 32'd9, 64'd0, 1'b1, 1'b1);
    wait_ve(ve);
    wait_rsp(rc);
    check("timeout_latency", 64'(rc - ve), 64'd17);
    never = 1'b0;
    @(posedge clk); #1;
    issue(1, 32'h0001_0000, 32'h0001_0000, 64'h1_0000_0000, 1'b0, 1'b1);
    wait_ve(ve);
    wait_rsp(rc);
    check("normal_latency", 64'(rc - ve), 64'(MulLat + 1));
    @(posedge clk); #1;

    // Clock enable low for 5 cycles during WAIT
    issue(0, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 64'hFFFF_FFFF_8000_0001, 1'b0, 1'b1);
    wait_ve(ve);
    @(posedge clk); #1;
    @(posedge clk); #1;
    clk_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("freeze_state", {62'd0, rsp_valid, mul_ve}, 64'd0);
      check("freeze_operand", 64'(mul_a), 64'hFFFF_FFFF);
      @(posedge clk); #1;
    end
    clk_en = 1'b1;
    wait_rsp(rc);
    check("freeze_latency", 64'(rc - ve), 64'(MulLat + 1 + 5));
    @(posedge clk); #1;

    // Reset during WAIT: aborted, next grant goes to requester 0
    issue(2, 32'd3, 32'd3, 64'd9, 1'b0, 1'b0);
    wait_ve(ve);
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("abort_outputs",
          {57'd0, rsp_valid, rsp_error, rsp_id, mul_ve, req_ready == 4'h0},
          {57'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1});
    check("abort_result", rsp_result, 64'd0);
    check("abort_operands", {mul_a, mul_b}, 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      opa[k*32 +: 32] = 32'(k + 1);
      opb[k*32 +: 32] = 32'd10;
    end
    e.id = 2'd0; e.res = 64'd10; e.err = 1'b0;
    q.push_back(e);
    req_valid = 4'hF;
    @(negedge clk);
    check("post_reset_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1 req_valid = 4'h0;

    // Drain
    n = 0;
    while (q.size() != 0 && n < 500) begin
      n++;
      @(negedge clk);
    end
    repeat (5) @(posedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);
    check("valid_entry_total", 64'(ve_count), 64'd16);
    check("valid_entry_single_cycle", 64'(ve_double), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
Name: mul_share_arbiter

Overview:
- Shares one multi-cycle integer multiplier (e.g. radix-16 booth_multiplier, 32-bit, 9-cycle latency) between NUM_REQ requesters.
- Round-robin arbitration, one operation in flight at a time.
- Sequences the multiplier's valid_entry/busy/data_valid protocol and returns the product, tagged with the requester ID, over a valid/ready response channel.
- A watchdog flags a multiplier that never asserts data_valid.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, operand width; product is 2*DATA_WIDTH.
- TIMEOUT, 16, max cycles in WAIT before abort (must exceed multiplier latency).
- ID_WIDTH, $clog2(NUM_REQ), derived localparam, width of rsp_id_o.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- clk_en_i  in  1  clock enable; low freezes all registers
- req_valid_i  in  NUM_REQ  per-requester request valid
- req_ready_o  out  NUM_REQ  one-hot accept
- req_operand_A_i  in  NUM_REQ*DATA_WIDTH  packed operand A; requester k at [k*DATA_WIDTH +: DATA_WIDTH]
- req_operand_B_i  in  NUM_REQ*DATA_WIDTH  packed operand B; same packing
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumer ready
- rsp_id_o  out  ID_WIDTH  requester index of response
- rsp_result_o  out  2*DATA_WIDTH  product
- rsp_error_o  out  1  response is a timeout abort
- mul_operand_A_o  out  DATA_WIDTH  to multiplier operand_A_i
- mul_operand_B_o  out  DATA_WIDTH  to multiplier operand_B_i
- mul_valid_entry_o  out  1  to multiplier valid_entry_i
- mul_result_i  in  2*DATA_WIDTH  from multiplier result_o
- mul_data_valid_i  in  1  from multiplier data_valid_o
- mul_busy_i  in  1  from multiplier busy_o

Behaviour:
- Reset (rst_n_i low at posedge, regardless of clk_en_i): state=IDLE; all outputs 0; rr pointer=NUM_REQ-1 (requester 0 highest priority first); watchdog=0.
- clk_en_i low: state, pointer, latches and counter hold; outputs hold their values. Multiplier shares the same clk_en_i.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Grant = first k with req_valid_i[k]=1, searching ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready_o = one-hot grant (combinational, only in IDLE, only when some valid is high).
  - Handshake at that edge: latch operands and ID, go ISSUE.
  - mul_data_valid_i is ignored in IDLE.
- ISSUE:
  - mul_operand_A_o/mul_operand_B_o driven from the latches; held stable from ISSUE through WAIT.
  - If mul_busy_i=0: mul_valid_entry_o=1 for exactly this cycle, load watchdog=TIMEOUT, go WAIT.
  - If mul_busy_i=1: stay in ISSUE with mul_valid_entry_o=0.
- WAIT:
  - mul_data_valid_i=1: capture mul_result_i into rsp_result_o, rsp_error_o=0, go RESP.
  - Otherwise decrement watchdog. At 1 with no data_valid: rsp_result_o=0, rsp_error_o=1, go RESP.
  - data_valid on the same cycle as watchdog expiry: the result wins, no error.
- RESP:
  - rsp_valid_o=1; rsp_id_o, rsp_result_o, rsp_error_o stable until rsp_ready_i=1 at an edge.
  - On that edge: ptr=granted ID, rsp_valid_o=0, go IDLE.
- Latency: accept at edge T, valid_entry at cycle T+1 (busy clear), rsp_valid_o the cycle after data_valid is sampled. Minimum throughput: one op per MUL_LATENCY+3 cycles.
- Requests are never dropped: a requester holding req_valid_i keeps its operands stable until req_ready_o; starvation-free within NUM_REQ grants.
- Reset mid-operation: abort, no response emitted. The multiplier is reset by the same rst_n_i; any stale data_valid is ignored because the FSM is in IDLE.
- Only one operation outstanding; no pipelining of the multiplier.

Test Plan:
- Single request: req 2, A=7, B=-3 (signed multiplier) -> one rsp with id=2, result=64'hFFFF_FFFF_FFFF_FFEB, error=0; mul_valid_entry_o high exactly 1 cycle.
- All 4 requesters valid continuously from reset, A=k+1, B=10 -> responses in id order 0,1,2,3,0,... with results 10,20,30,40; no id granted twice before all others are served.
- rsp_ready_i held low 20 cycles after rsp_valid_o -> outputs stable, req_ready_o all 0, no new valid_entry; release -> IDLE next cycle.
- Stub multiplier never asserting data_valid, TIMEOUT=16 -> rsp_error_o=1, result=0 exactly 17 cycles after valid_entry; next request served normally.
- clk_en_i low for 5 cycles during WAIT -> state and watchdog frozen; correct result delivered once re-enabled.
- rst_n_i low 1 cycle during WAIT -> all outputs 0 next cycle, no response for the aborted op; next grant goes to requester 0.
